// File: rtl/tdm_demux_14_pkg.sv
// tdm_defs: shared definitions for the TDM demultiplexer.
//   W_DEF / NCH_DEF : default sample width and channels per frame
//   tdm_state_t     : frame-alignment FSM states (HUNT=0, LOCKED=1)
//   slot_after()    : slot index that follows a given slot, wrapping at nch
package tdm_defs;

   localparam int W_DEF   = 1;
   localparam int NCH_DEF = 4;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   function automatic int slot_after(input int slot, input int nch);
      return (slot + 1) % nch;
   endfunction

endpackage

// File: rtl/tdm_demux_14_slot_dec.sv
// slot_dec: binary-to-one-hot decoder with enable.
//   idx : binary slot index (SW bits)
//   en  : when low all outputs are zero
//   oh  : one-hot decode, oh[idx]=en
module slot_dec #(
   parameter int NCH = 4,
   parameter int SW  = $clog2(NCH)
) (
   input  logic [SW-1:0]  idx,
   input  logic           en,
   output logic [NCH-1:0] oh
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
      assign oh[gi] = en && (idx == SW'(gi));
   end

endmodule

// File: rtl/tdm_demux_14.sv
// tdm_demux_14: time-division demultiplexer with frame-alignment FSM.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : incoming sample (W bits)
//   din_valid   : din carries a sample this cycle
//   frame_sync  : marks din as the channel-0 sample
//   y           : last complete frame, channel c at y[c*W +: W]
//   frame_valid : one-cycle pulse when y has just been updated
//   slot_oh     : one-hot slot expected for the next sample (zero in HUNT)
//   locked      : FSM is in LOCKED
//   sync_err    : one-cycle pulse on an alignment violation
module tdm_demux_14
   import tdm_defs::*;
#(
   parameter int W   = W_DEF,
   parameter int NCH = NCH_DEF,
   parameter int SW  = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [NCH*W-1:0] y,
   output logic             frame_valid,
   output logic [NCH-1:0]   slot_oh,
   output logic             locked,
   output logic             sync_err
);

   tdm_state_t       state, state_next;
   logic [SW-1:0]    cnt, cnt_next;
   logic [SW-1:0]    wr_idx;
   logic             wr_en;
   logic             err_next;
   logic [NCH-1:0]   wr_oh;
   logic [NCH-1:0]   slot_oh_next;
   logic [NCH*W-1:0] y_next;
   logic [W-1:0]     cap_buf [NCH-1];

   // An accepted sample either starts a frame (index 0) or fills slot cnt.
   // Only a missing sync in LOCKED, or a non-sync sample in HUNT, is dropped.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      wr_en      = 1'b0;
      wr_idx     = '0;
      err_next   = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (frame_sync) begin
                  wr_en      = 1'b1;
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // Early sync realigns on this sample; partial frame is lost.
                  wr_en    = 1'b1;
                  err_next = (cnt != '0);
               end else if (cnt != '0) begin
                  wr_en  = 1'b1;
                  wr_idx = cnt;
               end else begin
                  err_next   = 1'b1;
                  state_next = HUNT;
                  cnt_next   = '0;
               end
            end
            default: state_next = HUNT;
         endcase
         if (wr_en) begin
            cnt_next = SW'(slot_after(int'(wr_idx), NCH));
         end
      end
   end

   // Write-enable decode; the top bit doubles as the frame-complete strobe
   // because the last slot is never stored, it goes straight to y with din.
   slot_dec #(.NCH(NCH), .SW(SW)) u_wr_dec (
      .idx (wr_idx),
      .en  (wr_en),
      .oh  (wr_oh)
   );

   // slot_oh is the registered decode of the slot the next sample will fill.
   slot_dec #(.NCH(NCH), .SW(SW)) u_slot_dec (
      .idx (cnt_next),
      .en  (state_next == LOCKED),
      .oh  (slot_oh_next)
   );

   for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_buf
      assign y_next[gi*W +: W] = cap_buf[gi];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cap_buf[gi] <= '0;
         end else if (wr_oh[gi]) begin
            cap_buf[gi] <= din;
         end
      end
   end
   assign y_next[(NCH-1)*W +: W] = din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         cnt         <= '0;
         y           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         slot_oh     <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         frame_valid <= wr_oh[NCH-1];
         sync_err    <= err_next;
         slot_oh     <= slot_oh_next;
         if (wr_oh[NCH-1]) begin
            y <= y_next;
         end
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_14.sv
module tb_tdm_demux_14;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [0:0] din = '0;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic [3:0] y;
   logic       frame_valid;
   logic [3:0] slot_oh;
   logic       locked;
   logic       sync_err;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q [$];

   tdm_demux_14 #(.W(1), .NCH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .y           (y),
      .frame_valid (frame_valid),
      .slot_oh     (slot_oh),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every frame_valid pulse must match the oldest
   // expected frame pushed by the stimulus.
   always @(negedge clk) begin
      if (rst_n && frame_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got y=%b, no frame expected", y);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (y !== e) begin
               errors++;
               $display("FAIL frame_y: got y=%b, expected %b", y, e);
            end else begin
               $display("frame y=%b ok", y);
            end
         end
      end
   end

   // Present one sample for one edge; return the outputs seen just after it.
   task automatic send(input logic d, input logic fs,
                       output logic fv, output logic err, output logic [3:0] oh);
      @(negedge clk);
      din        = d;
      frame_sync = fs;
      din_valid  = 1'b1;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      fv  = frame_valid;
      err = sync_err;
      oh  = slot_oh;
      $display("sample din=%b sync=%b -> fv=%b err=%b slot_oh=%b locked=%b y=%b",
               d, fs, fv, err, oh, locked, y);
   endtask

   task automatic test_reset();
      logic fv, err;
      logic [3:0] oh;
      rst_n = 1'b0;
      din = 1'b1; din_valid = 1'b1; frame_sync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (y !== 4'b0000 || locked !== 1'b0 || slot_oh !== 4'b0000 ||
          frame_valid !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: y=%b locked=%b slot_oh=%b fv=%b err=%b, expected all zero",
                  y, locked, slot_oh, frame_valid, sync_err);
      end
      @(negedge clk);
      din_valid = 1'b0; frame_sync = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (locked !== 1'b0 || slot_oh !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: locked=%b slot_oh=%b, expected 0/0000", locked, slot_oh);
      end
      // A non-sync sample in HUNT is discarded silently.
      send(1'b1, 1'b0, fv, err, oh);
      checks++;
      if (locked !== 1'b0 || err !== 1'b0 || fv !== 1'b0 || oh !== 4'b0000) begin
         errors++;
         $display("FAIL hunt_discard: locked=%b err=%b fv=%b slot_oh=%b, expected 0/0/0/0000",
                  locked, err, fv, oh);
      end
   endtask

   task automatic test_basic();
      logic fv, err;
      logic [3:0] oh, exp_oh;
      for (int f = 0; f < 4; f++) begin
         for (int s = 0; s < 4; s++) begin
            if (s == 3) exp_q.push_back(4'(1 << f));
            send(logic'(s == f), logic'(s == 0), fv, err, oh);
            exp_oh = 4'(1 << ((s + 1) % 4));
            checks++;
            if (oh !== exp_oh || fv !== logic'(s == 3) || err !== 1'b0 || locked !== 1'b1) begin
               errors++;
               $display("FAIL basic f%0d s%0d: slot_oh=%b fv=%b err=%b locked=%b, expected %b/%b/0/1",
                        f, s, oh, fv, err, locked, exp_oh, logic'(s == 3));
            end
         end
      end
   endtask

   task automatic test_gapped();
      logic fv, err;
      logic [3:0] oh, exp_oh;
      logic [3:0] pat;
      pat = 4'b1011;
      for (int s = 0; s < 4; s++) begin
         if (s == 3) exp_q.push_back(pat);
         send(pat[s], logic'(s == 0), fv, err, oh);
         exp_oh = 4'(1 << ((s + 1) % 4));
         checks++;
         if (oh !== exp_oh || fv !== logic'(s == 3) || err !== 1'b0) begin
            errors++;
            $display("FAIL gapped s%0d: slot_oh=%b fv=%b err=%b, expected %b/%b/0",
                     s, oh, fv, err, exp_oh, logic'(s == 3));
         end
         repeat (3) @(posedge clk);
         #1;
         checks++;
         if (slot_oh !== exp_oh || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL gapped_hold s%0d: slot_oh=%b fv=%b err=%b, expected %b/0/0",
                     s, slot_oh, frame_valid, sync_err, exp_oh);
         end
      end
   endtask

   task automatic test_early_sync();
      logic fv, err;
      logic [3:0] oh;
      logic d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         if (i == 5) exp_q.push_back(4'b0110);
         send(d[i], s[i], fv, err, oh);
         checks++;
         if (err !== logic'(i == 2) || fv !== logic'(i == 5) || locked !== 1'b1) begin
            errors++;
            $display("FAIL early_sync i%0d: err=%b fv=%b locked=%b, expected %b/%b/1",
                     i, err, fv, locked, logic'(i == 2), logic'(i == 5));
         end
      end
   endtask

   task automatic test_missing_sync();
      logic fv, err;
      logic [3:0] oh;
      logic [3:0] pat;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(4'b1111);
         send(1'b1, logic'(i == 0), fv, err, oh);
      end
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 1'b0, fv, err, oh);
         checks++;
         if (err !== logic'(i == 0) || locked !== 1'b0 || fv !== 1'b0 ||
             oh !== 4'b0000 || y !== 4'b1111) begin
            errors++;
            $display("FAIL missing_sync i%0d: err=%b locked=%b fv=%b slot_oh=%b y=%b, expected %b/0/0/0000/1111",
                     i, err, locked, fv, oh, y, logic'(i == 0));
         end
      end
      pat = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(pat);
         send(pat[i], logic'(i == 0), fv, err, oh);
         checks++;
         if (locked !== 1'b1 || err !== 1'b0 || fv !== logic'(i == 3)) begin
            errors++;
            $display("FAIL relock i%0d: locked=%b err=%b fv=%b, expected 1/0/%b",
                     i, locked, err, fv, logic'(i == 3));
         end
      end
      checks++;
      if (y !== 4'b0101) begin
         errors++;
         $display("FAIL relock_y: got y=%b, expected 0101", y);
      end
   endtask

   task automatic test_reset_mid();
      logic fv, err;
      logic [3:0] oh;
      send(1'b1, 1'b1, fv, err, oh);
      send(1'b0, 1'b0, fv, err, oh);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y !== 4'b0000 || locked !== 1'b0 || slot_oh !== 4'b0000 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: y=%b locked=%b slot_oh=%b fv=%b, expected 0000/0/0000/0",
                  y, locked, slot_oh, frame_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send(1'b1, 1'b0, fv, err, oh);
         checks++;
         if (locked !== 1'b0 || fv !== 1'b0 || err !== 1'b0 || y !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_hunt i%0d: locked=%b fv=%b err=%b y=%b, expected 0/0/0/0000",
                     i, locked, fv, err, y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_early_sync();
      test_missing_sync();
      test_reset_mid();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL frames_pending: %0d expected frames never produced, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux_14.md
Name: tdm_demux_14

Overview:
- Time-division demultiplexer: receives one sample stream in which consecutive samples belong to channels 0..NCH-1, and distributes each frame onto NCH parallel output channels.
- Receive-side counterpart of the team's 4:1 mux. Upstream serialises channels i0..i3 one per slot; this block reassembles them.
- Slot selection uses a binary-to-one-hot decoder.
- A frame-alignment FSM tracks the slot position and flags sync errors.

Parameters:
- W, 1: sample width in bits.
- NCH, 4: channels per frame; must be a power of 2 and at least 2.
- SW, $clog2(NCH): slot counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  incoming sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualifies din as the channel-0 sample; meaningful only when din_valid=1.
- y  output  NCH*W  reassembled frame; channel c occupies y[c*W +: W].
- frame_valid  output  1  one-cycle pulse: y has just been updated with a complete frame.
- slot_oh  output  NCH  one-hot slot expected for the next sample; all zero in HUNT.
- locked  output  1  FSM is in LOCKED.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, frame_valid=0, sync_err=0, locked=0, slot_oh=0.
  - Slot counter=0, capture buffer=0, FSM=HUNT.
  - Reset asserted mid-frame discards the partial frame; no frame_valid is produced for it.
- An accepted sample is din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing; gaps between samples are allowed anywhere.
- FSM HUNT:
  - Samples without frame_sync are discarded.
  - din_valid & frame_sync: store din in buf[0], cnt<=1, go to LOCKED.
- FSM LOCKED:
  - Sample with cnt!=0 and frame_sync=0: buf[cnt]<=din, cnt<=cnt+1.
  - Sample with cnt!=0 and frame_sync=1 (early sync): sync_err pulses. Partial frame discarded, no frame_valid. Realign: buf[0]<=din, cnt<=1, stay LOCKED.
  - Sample with cnt==0 and frame_sync=1: normal frame start; buf[0]<=din, cnt<=1.
  - Sample with cnt==0 and frame_sync=0 (missing sync): sync_err pulses, sample discarded, go to HUNT, cnt<=0.
- Frame completion: on the edge accepting the slot NCH-1 sample (cnt==NCH-1):
  - y <= {din, buf[NCH-2], ..., buf[0]}.
  - frame_valid=1 for exactly that following cycle.
  - cnt wraps to 0 and the FSM stays LOCKED.
- Output latency: y and frame_valid become visible 1 clock after the last-slot sample is presented.
- y holds its value between completions; a frame is never partially visible on y.
- slot_oh: registered decode of cnt while LOCKED (slot_oh[cnt]=1), otherwise 0.
- sync_err and frame_valid are never asserted in the same cycle.

Decomposition:
- Shared package/include tdm_defs: NCH/W defaults, FSM state encodings (HUNT=1'b0, LOCKED=1'b1), and a slot-index function.
- One natural sub-module, slot_dec: SW-to-NCH binary-to-one-hot decoder with an enable input. It drives slot_oh and the buffer write enables.

Test Plan (W=1, NCH=4):
- Reset sanity:
  - Stimulus: hold rst_n=0 while driving din=1, din_valid=1.
  - Required: y=4'b0000, locked=0, slot_oh=0, no pulses.
  - Stimulus: release rst_n.
  - Required: still HUNT until the first sync.
- Basic frame:
  - Stimulus: valid samples 1,0,0,0 with sync on the first; then 0,1,0,0; then 0,0,1,0; then 0,0,0,1 (one-hot per frame).
  - Required: y = 4'b0001, 4'b0010, 4'b0100, 4'b1000 in turn, each with a one-cycle frame_valid, 1 clock after the 4th sample.
  - Required: slot_oh steps 0001→0010→0100→1000→0001.
- Gapped input:
  - Stimulus: frame 1,1,0,1 with din_valid=0 for 3 cycles between each sample.
  - Required: y=4'b1011, a single frame_valid, and slot_oh holding during the gaps.
- Early sync:
  - Stimulus: sync+1, then 1, then sync+0, then 1,1,0.
  - Required: sync_err pulses at the 3rd sample and no frame_valid for the partial frame.
  - Required: next y=4'b0110, locked stays 1.
- Missing sync:
  - Stimulus: after a good frame, 4 valid samples with frame_sync=0.
  - Required: sync_err pulses on the first, locked=0, and y is unchanged.
  - Stimulus: sync with 1,0,1,0.
  - Required: locks again, y=4'b0101.
- Reset mid-frame:
  - Stimulus: pulse rst_n low after 2 of 4 samples.
  - Required: y=0 at once (asynchronous), no frame_valid, and HUNT after release.
